cache_controller: RTL and testbench

- Sits between the MEM pipeline stage and the SRAM controller, in front of the 2-way set-associative data cache (17-bit word address split as 10-bit tag, 6-bit row, 1-bit col; 64-bit lines).
- Serves read hits in zero wait cycles.
- On a read miss, fetches the 64-bit line from SRAM and fills the cache.
- Handles writes as write-through with no write-allocate: a hit line is invalidated and the word is written to SRAM.
- Drives `ready` low to freeze the pipeline while SRAM is busy.

---
 rtl/cache_controller_pkg.sv | 18 +
 rtl/cache_controller_sat_counter.sv | 24 ++
 rtl/cache_controller.sv | 136 +++++++++++++
 tb/tb_cache_controller.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared types and constants for the data-cache controller.
// Holds FSM state encodings, the data base address and cache field widths.
package cache_controller_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } cc_state_t;

    localparam logic [31:0] C_DATA_BASE = 32'd1024;

    localparam int TAG_W  = 10;
    localparam int ROW_W  = 6;
    localparam int COL_W  = 1;
    localparam int CADR_W = TAG_W + ROW_W + COL_W;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Saturating up-counter; holds at all ones instead of wrapping.
// Ports: clk, rst (async active-low), i_inc, o_count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cache_controller.sv
// Data-cache controller between the MEM stage and the SRAM controller.
// Ports: MEM request (address/wdata/mem_*), cache strobes, SRAM handshake, hit/miss counters.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter logic [31:0] DATA_BASE = C_DATA_BASE,
    parameter int          HIT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          address,
    input  logic [31:0]          wdata,
    input  logic                 mem_r_en,
    input  logic                 mem_w_en,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic [CADR_W-1:0]    cache_address,
    output logic [63:0]          cache_write_data,
    output logic                 cache_read_en,
    output logic                 cache_write_en,
    output logic                 cache_invalidate,
    input  logic [31:0]          cache_read_data,
    input  logic                 cache_hit,
    output logic [31:0]          sram_address,
    output logic [31:0]          sram_wdata,
    output logic                 sram_r_en,
    output logic                 sram_w_en,
    input  logic [63:0]          sram_rdata,
    input  logic                 sram_ready,
    output logic [HIT_CNT_W-1:0] hit_count,
    output logic [HIT_CNT_W-1:0] miss_count
);

    cc_state_t          r_state;
    cc_state_t          w_state_n;
    logic [CADR_W-1:0]  w_adj;
    logic               w_col;
    logic               w_hit_inc;
    logic               w_miss_inc;

    // DATA_BASE is word aligned, so only the word-address bits need subtracting.
    assign w_adj         = address[18:2] - DATA_BASE[18:2];
    assign w_col         = w_adj[0];
    assign cache_address = w_adj;
    assign sram_address  = address;
    assign sram_wdata    = wdata;
    assign cache_write_data = sram_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n        = r_state;
        ready            = 1'b1;
        rdata            = cache_read_data;
        cache_read_en    = 1'b0;
        cache_write_en   = 1'b0;
        cache_invalidate = 1'b0;
        sram_r_en        = 1'b0;
        sram_w_en        = 1'b0;
        w_hit_inc        = 1'b0;
        w_miss_inc       = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Store wins over a simultaneous load.
                if (mem_w_en) begin
                    cache_invalidate = 1'b1;
                    sram_w_en        = 1'b1;
                    ready            = 1'b0;
                    w_state_n        = WRITE;
                end else if (mem_r_en) begin
                    if (cache_hit) begin
                        cache_read_en = 1'b1;
                        w_hit_inc     = 1'b1;
                    end else begin
                        sram_r_en  = 1'b1;
                        ready      = 1'b0;
                        w_miss_inc = 1'b1;
                        w_state_n  = READ_MISS;
                    end
                end
            end
            READ_MISS: begin
                sram_r_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    cache_write_en = 1'b1;
                    rdata = w_col ? sram_rdata[63:32] : sram_rdata[31:0];
                    ready     = 1'b1;
                    w_state_n = IDLE;
                end
            end
            WRITE: begin
                sram_w_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    ready     = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
        // Strobes are forced quiet while reset is asserted.
        if (!rst) begin
            ready            = 1'b1;
            cache_read_en    = 1'b0;
            cache_write_en   = 1'b0;
            cache_invalidate = 1'b0;
            sram_r_en        = 1'b0;
            sram_w_en        = 1'b0;
            w_hit_inc        = 1'b0;
            w_miss_inc       = 1'b0;
            w_state_n        = IDLE;
        end
    end

    sat_counter #(.W(HIT_CNT_W)) u_hit_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_hit_inc),
        .o_count (hit_count)
    );

    sat_counter #(.W(HIT_CNT_W)) u_miss_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_miss_inc),
        .o_count (miss_count)
    );

endmodule

// File: tb/tb_cache_controller.sv
// Directed testbench for cache_controller.
// A second instance with 2-bit counters shares the stimulus for saturation.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    logic [31:0] rdata;
    logic        ready;
    logic [16:0] cache_address;
    logic [63:0] cache_write_data;
    logic        cache_read_en;
    logic        cache_write_en;
    logic        cache_invalidate;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_r_en;
    logic        sram_w_en;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    logic [31:0] s_rdata;
    logic        s_ready;
    logic [16:0] s_cache_address;
    logic [63:0] s_cache_write_data;
    logic        s_cache_read_en;
    logic        s_cache_write_en;
    logic        s_cache_invalidate;
    logic [31:0] s_sram_address;
    logic [31:0] s_sram_wdata;
    logic        s_sram_r_en;
    logic        s_sram_w_en;
    logic [1:0]  s_hit_count;
    logic [1:0]  s_miss_count;

    int total;
    int bad;

    cache_controller dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .rdata(rdata), .ready(ready),
        .cache_address(cache_address),
        .cache_write_data(cache_write_data),
        .cache_read_en(cache_read_en),
        .cache_write_en(cache_write_en),
        .cache_invalidate(cache_invalidate),
        .cache_read_data(cache_read_data), .cache_hit(cache_hit),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.HIT_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .rdata(s_rdata), .ready(s_ready),
        .cache_address(s_cache_address),
        .cache_write_data(s_cache_write_data),
        .cache_read_en(s_cache_read_en),
        .cache_write_en(s_cache_write_en),
        .cache_invalidate(s_cache_invalidate),
        .cache_read_data(cache_read_data), .cache_hit(cache_hit),
        .sram_address(s_sram_address), .sram_wdata(s_sram_wdata),
        .sram_r_en(s_sram_r_en), .sram_w_en(s_sram_w_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        address         = 32'd1024;
        wdata           = 32'd0;
        mem_r_en        = 1'b0;
        mem_w_en        = 1'b0;
        cache_read_data = 32'd0;
        cache_hit       = 1'b0;
        sram_rdata      = 64'd0;
        sram_ready      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", ready);
        end
        total++;
        if ({hit_count, miss_count} !== 32'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%h/%h exp=0/0", hit_count, miss_count);
        end
        total++;
        if ({sram_r_en, sram_w_en, cache_read_en, cache_write_en,
             cache_invalidate} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b%b%b%b%b exp=00000",
                     sram_r_en, sram_w_en, cache_read_en,
                     cache_write_en, cache_invalidate);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_miss_then_hit();
        @(negedge clk);
        address   = 32'd1032;
        mem_r_en  = 1'b1;
        cache_hit = 1'b0;
        #1;
        total++;
        if (cache_address !== 17'd2) begin
            bad++;
            $display("FAIL miss_caddr got=%0d exp=2", cache_address);
        end
        total++;
        if ({sram_r_en, ready, cache_read_en} !== 3'b100) begin
            bad++;
            $display("FAIL miss_start got=%b%b%b exp=100",
                     sram_r_en, ready, cache_read_en);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({sram_r_en, ready, cache_write_en} !== 3'b100) begin
                bad++;
                $display("FAIL miss_wait%0d got=%b%b%b exp=100", i,
                         sram_r_en, ready, cache_write_en);
            end
        end
        total++;
        if (miss_count !== 16'd1) begin
            bad++;
            $display("FAIL miss_cnt1 got=%0d exp=1", miss_count);
        end
        @(negedge clk);
        sram_ready = 1'b1;
        sram_rdata = 64'hBBBB_0000_AAAA_0000;
        #1;
        total++;
        if ({cache_write_en, ready, sram_r_en} !== 3'b111) begin
            bad++;
            $display("FAIL fill_strobe got=%b%b%b exp=111",
                     cache_write_en, ready, sram_r_en);
        end
        total++;
        if (rdata !== 32'hAAAA_0000) begin
            bad++;
            $display("FAIL fill_even got=%h exp=aaaa0000", rdata);
        end
        total++;
        if (cache_write_data !== 64'hBBBB_0000_AAAA_0000) begin
            bad++;
            $display("FAIL fill_data got=%h exp=bbbb0000aaaa0000",
                     cache_write_data);
        end
        @(negedge clk);
        sram_ready      = 1'b0;
        cache_hit       = 1'b1;
        cache_read_data = 32'h5555_1111;
        #1;
        total++;
        if ({cache_write_en, ready, cache_read_en, sram_r_en} !== 4'b0110) begin
            bad++;
            $display("FAIL hit_strobe got=%b%b%b%b exp=0110",
                     cache_write_en, ready, cache_read_en, sram_r_en);
        end
        total++;
        if (rdata !== 32'h5555_1111) begin
            bad++;
            $display("FAIL hit_rdata got=%h exp=55551111", rdata);
        end
        @(posedge clk);
        #1;
        total++;
        if ({hit_count, miss_count} !== {16'd1, 16'd1}) begin
            bad++;
            $display("FAIL hit_cnt got=%0d/%0d exp=1/1", hit_count, miss_count);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_odd_fill();
        @(negedge clk);
        address   = 32'd1036;
        mem_r_en  = 1'b1;
        cache_hit = 1'b0;
        #1;
        total++;
        if (cache_address !== 17'd3) begin
            bad++;
            $display("FAIL odd_caddr got=%0d exp=3", cache_address);
        end
        @(negedge clk);
        sram_ready = 1'b1;
        sram_rdata = 64'h1234_5678_9ABC_DEF0;
        #1;
        total++;
        if (rdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL odd_rdata got=%h exp=12345678", rdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if ({miss_count, cache_write_en} !== {16'd2, 1'b0}) begin
            bad++;
            $display("FAIL odd_after got=%0d/%b exp=2/0",
                     miss_count, cache_write_en);
        end
    endtask

    task automatic test_store_hit();
        @(negedge clk);
        address   = 32'd1024;
        wdata     = 32'hDEAD_BEEF;
        mem_w_en  = 1'b1;
        cache_hit = 1'b1;
        #1;
        total++;
        if ({cache_invalidate, sram_w_en, ready, cache_read_en,
             cache_write_en} !== 5'b11000) begin
            bad++;
            $display("FAIL st_first got=%b%b%b%b%b exp=11000",
                     cache_invalidate, sram_w_en, ready,
                     cache_read_en, cache_write_en);
        end
        total++;
        if (sram_wdata !== 32'hDEAD_BEEF || sram_address !== 32'd1024) begin
            bad++;
            $display("FAIL st_bus got=%h@%0d exp=deadbeef@1024",
                     sram_wdata, sram_address);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({cache_invalidate, sram_w_en, ready, cache_write_en}
                !== 4'b0100) begin
                bad++;
                $display("FAIL st_wait%0d got=%b%b%b%b exp=0100", i,
                         cache_invalidate, sram_w_en, ready, cache_write_en);
            end
        end
        @(negedge clk);
        sram_ready = 1'b1;
        #1;
        total++;
        if ({ready, sram_w_en, cache_invalidate, cache_write_en}
            !== 4'b1100) begin
            bad++;
            $display("FAIL st_done got=%b%b%b%b exp=1100",
                     ready, sram_w_en, cache_invalidate, cache_write_en);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if ({ready, sram_w_en} !== 2'b10) begin
            bad++;
            $display("FAIL st_idle got=%b%b exp=10", ready, sram_w_en);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        address   = 32'd1040;
        mem_r_en  = 1'b1;
        mem_w_en  = 1'b1;
        cache_hit = 1'b1;
        #1;
        total++;
        if ({cache_read_en, sram_r_en, sram_w_en, cache_invalidate}
            !== 4'b0011) begin
            bad++;
            $display("FAIL rw_first got=%b%b%b%b exp=0011",
                     cache_read_en, sram_r_en, sram_w_en, cache_invalidate);
        end
        @(negedge clk);
        sram_ready = 1'b1;
        #1;
        total++;
        if ({ready, cache_read_en} !== 2'b10) begin
            bad++;
            $display("FAIL rw_done got=%b%b exp=10", ready, cache_read_en);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        total++;
        if ({hit_count, miss_count} !== {16'd1, 16'd2}) begin
            bad++;
            $display("FAIL rw_cnt got=%0d/%0d exp=1/2", hit_count, miss_count);
        end
    endtask

    task automatic test_idle_sram_ready();
        @(negedge clk);
        sram_ready = 1'b1;
        #1;
        total++;
        if ({ready, cache_write_en, sram_r_en, sram_w_en} !== 4'b1000) begin
            bad++;
            $display("FAIL idle_srdy got=%b%b%b%b exp=1000",
                     ready, cache_write_en, sram_r_en, sram_w_en);
        end
        @(negedge clk);
        sram_ready = 1'b0;
        mem_r_en   = 1'b1;
        cache_hit  = 1'b1;
        #1;
        total++;
        if ({ready, cache_read_en} !== 2'b11) begin
            bad++;
            $display("FAIL idle_next got=%b%b exp=11", ready, cache_read_en);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        address  = 32'd1048;
        mem_r_en = 1'b1;
        repeat (2) @(negedge clk);
        sram_ready = 1'b1;
        sram_rdata = 64'h0F0F_0F0F_F0F0_F0F0;
        rst        = 1'b0;
        #1;
        total++;
        if ({sram_r_en, ready, cache_write_en} !== 3'b010) begin
            bad++;
            $display("FAIL rstmid_str got=%b%b%b exp=010",
                     sram_r_en, ready, cache_write_en);
        end
        total++;
        if ({hit_count, miss_count} !== 32'd0) begin
            bad++;
            $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0",
                     hit_count, miss_count);
        end
        @(negedge clk);
        rst        = 1'b1;
        sram_ready = 1'b0;
        cache_hit  = 1'b1;
        #1;
        total++;
        if ({cache_read_en, sram_r_en, ready} !== 3'b101) begin
            bad++;
            $display("FAIL rstmid_idle got=%b%b%b exp=101",
                     cache_read_en, sram_r_en, ready);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        address   = 32'd1024;
        mem_r_en  = 1'b1;
        cache_hit = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            exp_s = (i >= 3) ? 2'b11 : 2'(i);
            total++;
            if (s_hit_count !== exp_s) begin
                bad++;
                $display("FAIL sat_hit%0d got=%b exp=%b", i, s_hit_count, exp_s);
            end
        end
        total++;
        if (hit_count !== 16'd5) begin
            bad++;
            $display("FAIL sat_wide got=%0d exp=5", hit_count);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        idle_inputs();
        test_reset();
        test_miss_then_hit();
        test_odd_fill();
        test_store_hit();
        test_simultaneous();
        test_idle_sram_ready();
        test_reset_mid_miss();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
